// File: rtl/rv_prims_pkg.sv
// Shared definitions for the core-datapath register primitives.
// Holds the width limit, the enable-style selector and the gate-enable rule.
package rv_prims_pkg;

    localparam int MAX_DFF_WIDTH = 32'sd1024;

    typedef enum logic {
        DFF_MUX   = 1'b0,
        DFF_GATED = 1'b1
    } dff_style_e;

    // The clock must also open for reset, otherwise a gated flop with en=0 could never clear.
    function automatic logic gate_open(input logic en, input logic rst);
        return en | rst;
    endfunction

    function automatic logic width_legal(input int width);
        return (width >= 32'sd1) && (width <= MAX_DFF_WIDTH);
    endfunction

endpackage

// File: rtl/rvdff_enable_if.sv
// Data-side bundle of the enabled register: load enable, data, test mode and registered output.
interface rvdff_enable_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] din;
    logic             scan_mode;
    logic [WIDTH-1:0] dout;

    modport master (
        output en,
        output din,
        output scan_mode,
        input  dout
    );

    modport slave (
        input  en,
        input  din,
        input  scan_mode,
        output dout
    );
endinterface

// File: rtl/rv_clkgate.sv
// Latch-based integrated clock gate: the enable is captured while clk is low and ANDed with clk,
// so an enable change during the high phase can never shorten or split a pulse.
module rv_clkgate (
    input  logic clk,
    input  logic en,
    input  logic scan_mode,
    output logic gclk
);

    logic en_latch_r;

    // Active-low transparent latch holding the gate enable stable across the high phase.
    always_latch begin
        if (!clk) begin
            en_latch_r <= en | scan_mode;
        end
    end

    assign gclk = clk & en_latch_r;

endmodule

// File: rtl/rvdff_enable.sv
// Enabled register primitive with synchronous active-high reset (rst_l keeps its legacy name).
// GATED selects a recirculating mux or a clock-gated flop; both give identical dout sequences.
module rvdff_enable
    import rv_prims_pkg::*;
#(
    parameter int         WIDTH = 1,
    parameter dff_style_e GATED = DFF_MUX
) (
    input logic           clk,
    input logic           rst_l,
    rvdff_enable_if.slave bus
);

    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] load_s;

    if (!width_legal(WIDTH)) begin : g_bad_width
        $fatal(1, "rvdff_enable: WIDTH out of range 1..MAX_DFF_WIDTH");
    end

    // Functional enable mux; kept in the gated build too so scan_mode cannot force a load.
    always_comb begin
        load_s = dout_r;
        if (bus.en) begin
            load_s = bus.din;
        end else begin
            load_s = dout_r;
        end
    end

    if (GATED == DFF_GATED) begin : g_gated
        logic gate_en_s;
        logic gclk_s;

        assign gate_en_s = gate_open(bus.en, rst_l);

        rv_clkgate u_cg (
            .clk       (clk),
            .en        (gate_en_s),
            .scan_mode (bus.scan_mode),
            .gclk      (gclk_s)
        );

        // State register on the gated clock; reset overrides the load mux.
        always_ff @(posedge gclk_s) begin
            if (rst_l) begin
                dout_r <= {WIDTH{1'b0}};
            end else begin
                dout_r <= load_s;
            end
        end
    end else begin : g_mux
        logic unused_scan_s;

        assign unused_scan_s = bus.scan_mode;

        // State register on the free-running clock; reset overrides the load mux.
        always_ff @(posedge clk) begin
            if (rst_l) begin
                dout_r <= {WIDTH{1'b0}};
            end else begin
                dout_r <= load_s;
            end
        end
    end

    assign bus.dout = dout_r;

endmodule

// File: tb/tb_rvdff_enable.sv
// Scoreboard bench: mux and gated instances at widths 8 and 64 share one random/directed stream;
// a reference model queues expected dout per edge and a monitor pops and compares after each edge.
module tb_rvdff_enable;
    import rv_prims_pkg::*;

    localparam int HALF = 5;

    typedef struct {
        logic [63:0] exp;
        string       tag;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic        en_s = 1'b0;
    logic        scan_s = 1'b0;
    logic [63:0] din_s = 64'h0;

    int n_checks = 0;
    int n_errors = 0;

    sb_item_t    sb_q[$];
    logic [63:0] model_val;
    string       cur_tag = "reset";
    longint      t_rise8 = 0;
    longint      t_rise64 = 0;

    always #(HALF) clk = ~clk;

    rvdff_enable_if #(.WIDTH(8))  bus_m8  ();
    rvdff_enable_if #(.WIDTH(8))  bus_g8  ();
    rvdff_enable_if #(.WIDTH(64)) bus_m64 ();
    rvdff_enable_if #(.WIDTH(64)) bus_g64 ();

    assign bus_m8.en         = en_s;
    assign bus_m8.scan_mode  = scan_s;
    assign bus_m8.din        = din_s[7:0];
    assign bus_g8.en         = en_s;
    assign bus_g8.scan_mode  = scan_s;
    assign bus_g8.din        = din_s[7:0];
    assign bus_m64.en        = en_s;
    assign bus_m64.scan_mode = scan_s;
    assign bus_m64.din       = din_s;
    assign bus_g64.en        = en_s;
    assign bus_g64.scan_mode = scan_s;
    assign bus_g64.din       = din_s;

    rvdff_enable #(.WIDTH(8), .GATED(DFF_MUX)) u_mux8 (
        .clk(clk), .rst_l(rst_l), .bus(bus_m8.slave)
    );
    rvdff_enable #(.WIDTH(8), .GATED(DFF_GATED)) u_gate8 (
        .clk(clk), .rst_l(rst_l), .bus(bus_g8.slave)
    );
    rvdff_enable #(.WIDTH(64), .GATED(DFF_MUX)) u_mux64 (
        .clk(clk), .rst_l(rst_l), .bus(bus_m64.slave)
    );
    rvdff_enable #(.WIDTH(64), .GATED(DFF_GATED)) u_gate64 (
        .clk(clk), .rst_l(rst_l), .bus(bus_g64.slave)
    );

    wire gclk8  = u_gate8.g_gated.gclk_s;
    wire gclk64 = u_gate64.g_gated.gclk_s;

    function automatic void check(input string tag, input string who,
                                  input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s [%s] t=%0t got=%h expected=%h", tag, who, $time, got, want);
        end
    endfunction

    // Register semantics from the rules: reset clears, else a load takes din, else the value is kept.
    function automatic logic [63:0] ref_next(input logic [63:0] cur, input logic rst,
                                             input logic ld, input logic [63:0] d);
        logic [63:0] r;
        r = cur;
        if (ld) r = d;
        if (rst) r = 64'h0;
        return r;
    endfunction

    task automatic drive(input logic rst, input logic ld, input logic scan, input logic [63:0] d);
        sb_item_t it;
        @(negedge clk);
        rst_l     = rst;
        en_s      = ld;
        scan_s    = scan;
        din_s     = d;
        model_val = ref_next(model_val, rst, ld, d);
        it.exp    = model_val;
        it.tag    = cur_tag;
        sb_q.push_back(it);
    endtask

    // en=0 is sampled at the edge; en is then pulsed high inside the clk-high phase only.
    task automatic glitch_cycle(input logic [63:0] d);
        drive(1'b0, 1'b0, 1'b0, d);
        @(posedge clk);
        #2;
        en_s = 1'b1;
        #2;
        en_s = 1'b0;
    endtask

    // Monitor: one expected value per issued edge, compared against all four instances.
    always @(posedge clk) begin
        sb_item_t it;
        #1;
        if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check(it.tag, "mux8",   {56'h0, bus_m8.dout},  {56'h0, it.exp[7:0]});
            check(it.tag, "gate8",  {56'h0, bus_g8.dout},  {56'h0, it.exp[7:0]});
            check(it.tag, "mux64",  bus_m64.dout, it.exp);
            check(it.tag, "gate64", bus_g64.dout, it.exp);
        end
    end

    always @(posedge gclk8)  t_rise8  = $time;
    always @(posedge gclk64) t_rise64 = $time;

    // Every gated pulse must last exactly one clk high phase.
    always @(negedge gclk8) begin
        n_checks++;
        if (($time - t_rise8) != HALF) begin
            n_errors++;
            $display("FAIL gclk8_width t=%0t got=%0d expected=%0d", $time, $time - t_rise8, HALF);
        end
    end

    always @(negedge gclk64) begin
        n_checks++;
        if (($time - t_rise64) != HALF) begin
            n_errors++;
            $display("FAIL gclk64_width t=%0t got=%0d expected=%0d", $time, $time - t_rise64, HALF);
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_val = 64'h0;

        cur_tag = "reset_over_load";
        drive(1'b1, 1'b1, 1'b0, {8{8'hA5}});
        drive(1'b1, 1'b1, 1'b0, {8{8'hA5}});
        cur_tag = "load_after_reset";
        drive(1'b0, 1'b1, 1'b0, {8{8'hA5}});

        cur_tag = "load";
        drive(1'b0, 1'b1, 1'b0, {8{8'h3C}});
        cur_tag = "hold";
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, {8{8'hFF}});

        cur_tag = "gated_reset_en0";
        drive(1'b1, 1'b0, 1'b0, {8{8'h3C}});

        cur_tag = "scan_reload";
        drive(1'b0, 1'b1, 1'b0, {8{8'h3C}});
        cur_tag = "scan_hold";
        drive(1'b0, 1'b0, 1'b1, {8{8'h55}});
        drive(1'b0, 1'b0, 1'b1, {8{8'h55}});
        cur_tag = "scan_load";
        drive(1'b0, 1'b1, 1'b1, {8{8'h55}});

        cur_tag = "glitch";
        for (int i = 0; i < 4; i++) glitch_cycle({$urandom, $urandom});
        cur_tag = "glitch_reload";
        drive(1'b0, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
        cur_tag = "glitch";
        glitch_cycle(64'hFFFF_FFFF_FFFF_FFFF);

        cur_tag = "random";
        for (int i = 0; i < 10000; i++) begin
            logic r_rst;
            logic r_en;
            logic r_scan;
            r_rst  = ($urandom_range(99) < 5);
            r_en   = $urandom_range(1);
            r_scan = ($urandom_range(3) == 0);
            drive(r_rst, r_en, r_scan, {$urandom, $urandom});
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain got=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
